// File: rtl/fft_sched_pkg.sv
// ---------------------------------------------------------------------------
// fft_sched_pkg
//   Shared types and constants for the FFT frame scheduler:
//     state_t              scheduler FSM states (IDLE, STREAM, WAIT_FFT)
//     ch_id_t, CH0, CH1    one-bit channel identifier and its two values
//     DEFAULT_NUM_SAMPLES  default frame length in beats
// ---------------------------------------------------------------------------
package fft_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        WAIT_FFT = 2'd2
    } state_t;

    typedef logic ch_id_t;

    localparam ch_id_t CH0 = 1'b0;
    localparam ch_id_t CH1 = 1'b1;

    localparam int DEFAULT_NUM_SAMPLES = 1024;

endpackage

// File: rtl/fft_frame_scheduler_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
//   Purely combinational two-way round-robin arbiter. A lone request wins
//   outright; on a tie the channel that was NOT served last wins.
//   Ports:
//     req0, req1  in   channel requests
//     last_ch     in   channel served most recently
//     grant       out  one-hot grant (bit N = channel N), 0 when no request
//     grant_id    out  index of the granted channel (CH0 when no request)
// ---------------------------------------------------------------------------
module rr_arbiter2
    import fft_sched_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  ch_id_t     last_ch,
    output logic [1:0] grant,
    output ch_id_t     grant_id
);

    // NOTE: every output gets a default at the top of the block so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        grant_id = CH0;
        if (req0 && req1) begin
            grant_id = (last_ch == CH0) ? CH1 : CH0;
        end else if (req1) begin
            grant_id = CH1;
        end

        grant = 2'b00;
        if (req0 || req1) begin
            grant = (grant_id == CH1) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/fft_frame_scheduler.sv
// ---------------------------------------------------------------------------
// fft_frame_scheduler
//   Shares one FFT core's AXI4-Stream input between two first-word-fall-
//   through capture FIFOs. A channel is granted a whole frame of NUM_SAMPLES
//   beats only once that many samples are buffered; ties go round-robin.
//   After the last beat the scheduler waits for the FFT to report frame
//   completion on m_axis_data_tlast before granting again.
//
//   Build option: define SCHED_TIMEOUT_EN to add a WAIT_FFT watchdog that
//   returns to IDLE after TIMEOUT_CYCLES and sets the sticky timeout_err.
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     chN_dout/empty/count     FIFO read data, empty flag, fill level
//     chN_rd_en                FIFO pop (one per accepted beat)
//     s_axis_t*                FFT input stream; tuser carries channel id
//     m_axis_data_tlast        FFT output last beat = frame completed
//     busy                     registered, high whenever not in IDLE
//     frame_done, frame_ch     completion pulse and its channel
//     timeout_err              sticky watchdog flag (0 without the option)
// ---------------------------------------------------------------------------
module fft_frame_scheduler
    import fft_sched_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_SAMPLES    = DEFAULT_NUM_SAMPLES,
    parameter int CNT_WIDTH      = 11,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ch0_dout,
    input  logic                  ch0_empty,
    input  logic [CNT_WIDTH-1:0]  ch0_count,
    output logic                  ch0_rd_en,
    input  logic [DATA_WIDTH-1:0] ch1_dout,
    input  logic                  ch1_empty,
    input  logic [CNT_WIDTH-1:0]  ch1_count,
    output logic                  ch1_rd_en,
    input  logic                  s_axis_tready,
    output logic                  s_axis_tvalid,
    output logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  s_axis_tlast,
    output logic                  s_axis_tuser,
    input  logic                  m_axis_data_tlast,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_ch,
    output logic                  timeout_err
);

    // Counter reaches NUM_SAMPLES after the final beat, so it needs one
    // value more than the beat indices; it is cleared on every grant.
    localparam int                BEAT_W    = $clog2(NUM_SAMPLES + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_SAMPLES - 1);

    state_t               state_q, state_d;
    ch_id_t               sel_q, sel_d;
    ch_id_t               last_ch_q, last_ch_d;
    ch_id_t               frame_ch_q, frame_ch_d;
    logic [BEAT_W-1:0]    cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;

    logic                 ch0_req, ch1_req;
    logic [1:0]           grant;
    ch_id_t               grant_id;
    logic                 sel_empty;
    logic [DATA_WIDTH-1:0] sel_dout;
    logic                 handshake;
    logic                 wd_expired;

    // A channel is eligible only once a full frame is buffered, so a granted
    // frame should never underrun.
    assign ch0_req = (32'(ch0_count) >= 32'(NUM_SAMPLES));
    assign ch1_req = (32'(ch1_count) >= 32'(NUM_SAMPLES));

    rr_arbiter2 u_arb (
        .req0     (ch0_req),
        .req1     (ch1_req),
        .last_ch  (last_ch_q),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign sel_empty = (sel_q == CH1) ? ch1_empty : ch0_empty;
    assign sel_dout  = (sel_q == CH1) ? ch1_dout  : ch0_dout;
    assign handshake = (state_q == STREAM) && !sel_empty && s_axis_tready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from the same clock edge, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= CH0;
            last_ch_q    <= CH1;   // channel 0 wins the first tie
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_ch_q   <= CH0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_ch_q    <= last_ch_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            frame_ch_q   <= frame_ch_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_ch_d    = last_ch_q;
        cnt_d        = cnt_q;
        frame_ch_d   = frame_ch_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|grant) begin
                    state_d = STREAM;
                    sel_d   = grant_id;
                    cnt_d   = '0;
                end
            end
            STREAM: begin
                if (handshake) begin
                    cnt_d = cnt_q + BEAT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = WAIT_FFT;
                    end
                end
            end
            WAIT_FFT: begin
                if (m_axis_data_tlast) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                    frame_ch_d   = sel_q;
                    last_ch_d    = sel_q;
                end else if (wd_expired) begin
                    // Abandon the frame silently; the other channel gets
                    // priority next time.
                    state_d   = IDLE;
                    last_ch_d = sel_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered busy tracks the state register exactly.
        busy_d = (state_d != IDLE);
    end

    // ------------------------------------------------------------------
    // Output logic: the stream is a combinational pass-through of the
    // selected FIFO head while in STREAM, and quiet otherwise.
    // ------------------------------------------------------------------
    always_comb begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = CH0;
        ch0_rd_en     = 1'b0;
        ch1_rd_en     = 1'b0;

        if (state_q == STREAM) begin
            s_axis_tvalid = !sel_empty;
            s_axis_tdata  = sel_dout;
            s_axis_tuser  = sel_q;
            s_axis_tlast  = !sel_empty && (cnt_q == LAST_BEAT);
            ch0_rd_en     = handshake && (sel_q == CH0);
            ch1_rd_en     = handshake && (sel_q == CH1);
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign frame_ch   = frame_ch_q;

    // ------------------------------------------------------------------
    // Optional WAIT_FFT watchdog
    // ------------------------------------------------------------------
`ifdef SCHED_TIMEOUT_EN
    localparam int            WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_err_q, timeout_err_d;

    // Counter value N means this is the (N+1)-th cycle spent in WAIT_FFT.
    assign wd_expired = (state_q == WAIT_FFT) && (wd_cnt_q == WD_LAST);

    always_comb begin
        wd_cnt_d = '0;
        if (state_q == WAIT_FFT) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
        // A completion arriving on the expiry cycle wins over the timeout.
        timeout_err_d = timeout_err_q || (wd_expired && !m_axis_data_tlast);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;

    assign wd_expired  = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_scheduler
//   Self-checking bench for fft_frame_scheduler with NUM_SAMPLES = 8 and
//   TIMEOUT_CYCLES = 20. Two simple FIFO models feed the scheduler; the
//   bench pushes known sample values and checks the stream it sees.
// ---------------------------------------------------------------------------
module tb_fft_frame_scheduler;

    localparam int DW = 16;
    localparam int NS = 8;
    localparam int CW = 11;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] ch0_dout, ch1_dout;
    logic          ch0_empty, ch1_empty;
    logic [CW-1:0] ch0_count, ch1_count;
    logic          ch0_rd_en, ch1_rd_en;
    logic          s_axis_tready;
    logic          s_axis_tvalid;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tlast;
    logic          s_axis_tuser;
    logic          m_axis_data_tlast;
    logic          busy, frame_done, frame_ch, timeout_err;

    int n_tests  = 0;
    int n_failed = 0;

    always #5 clk = ~clk;

    fft_frame_scheduler #(
        .DATA_WIDTH     (DW),
        .NUM_SAMPLES    (NS),
        .CNT_WIDTH      (CW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ch0_dout          (ch0_dout),
        .ch0_empty         (ch0_empty),
        .ch0_count         (ch0_count),
        .ch0_rd_en         (ch0_rd_en),
        .ch1_dout          (ch1_dout),
        .ch1_empty         (ch1_empty),
        .ch1_count         (ch1_count),
        .ch1_rd_en         (ch1_rd_en),
        .s_axis_tready     (s_axis_tready),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tuser      (s_axis_tuser),
        .m_axis_data_tlast (m_axis_data_tlast),
        .busy              (busy),
        .frame_done        (frame_done),
        .frame_ch          (frame_ch),
        .timeout_err       (timeout_err)
    );

    // ---------------- FIFO models (first-word-fall-through) ----------------
    logic [DW-1:0] mem0 [0:63];
    logic [DW-1:0] mem1 [0:63];
    int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;

    assign ch0_dout  = mem0[rp0[5:0]];
    assign ch1_dout  = mem1[rp1[5:0]];
    assign ch0_empty = (wp0 == rp0);
    assign ch1_empty = (wp1 == rp1);
    assign ch0_count = CW'(wp0 - rp0);
    assign ch1_count = CW'(wp1 - rp1);

    always @(posedge clk) begin
        if (ch0_rd_en) rp0 <= rp0 + 1;
        if (ch1_rd_en) rp1 <= rp1 + 1;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input logic [DW-1:0] d);
        if (ch == 0) begin
            mem0[wp0[5:0]] = d;
            wp0++;
        end else begin
            mem1[wp1[5:0]] = d;
            wp1++;
        end
    endtask

    // Wait out the FFT latency, then report completion and check the pulse.
    task automatic finish_frame(input logic exp_ch);
        repeat (5) tick();
        check("wait_busy", busy, 1);
        check("wait_tvalid", s_axis_tvalid, 0);
        check("wait_rd_en", {ch1_rd_en, ch0_rd_en}, 0);
        m_axis_data_tlast = 1'b1;
        tick();
        m_axis_data_tlast = 1'b0;
        check("frame_done_pulse", frame_done, 1);
        check("frame_ch", frame_ch, exp_ch);
        check("idle_after_done", busy, 0);
        tick();
        check("frame_done_one_cycle", frame_done, 0);
    endtask

    // Stream one full frame with tready held high.
    task automatic run_frame(input logic exp_ch, input logic [DW-1:0] first, input bit complete);
        int w;
        w = 0;
        s_axis_tready = 1'b1;
        while (!s_axis_tvalid && w < 10) begin
            tick();
            w++;
        end
        check("grant_within_bound", s_axis_tvalid, 1);
        check("grant_channel_tuser", s_axis_tuser, exp_ch);
        for (int b = 0; b < NS; b++) begin
            check("beat_tvalid", s_axis_tvalid, 1);
            check("beat_tdata", s_axis_tdata, first + DW'(b));
            check("beat_tlast", s_axis_tlast, (b == NS - 1));
            check("beat_rd_en", {ch1_rd_en, ch0_rd_en}, (exp_ch ? 2'b10 : 2'b01));
            tick();
        end
        check("post_frame_tvalid", s_axis_tvalid, 0);
        check("post_frame_busy", busy, 1);
        if (complete) finish_frame(exp_ch);
    endtask

    // ---------------- tready-toggle vector table ----------------
    typedef struct {
        logic          tready;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic          exp_last;
        logic          exp_user;
        logic          exp_rd0;
        logic          exp_rd1;
    } vec_t;

    vec_t vecs [16];

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        bit saw_done;

        // Channel 1 frame of 0x41..0x48, tready 0,1,0,1,...: each beat is
        // presented twice, accepted on the second cycle; tlast held until taken.
        for (int r = 0; r < 16; r++) begin
            vecs[r].tready    = r[0];
            vecs[r].exp_valid = 1'b1;
            vecs[r].exp_data  = 16'h0041 + DW'(r / 2);
            vecs[r].exp_last  = ((r / 2) == 7);
            vecs[r].exp_user  = 1'b1;
            vecs[r].exp_rd0   = 1'b0;
            vecs[r].exp_rd1   = r[0];
        end

        rst               = 1'b1;
        s_axis_tready     = 1'b0;
        m_axis_data_tlast = 1'b0;

        // ---- reset state ----
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_ch", frame_ch, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_tvalid", s_axis_tvalid, 0);
        check("rst_tlast", s_axis_tlast, 0);
        check("rst_tuser", s_axis_tuser, 0);
        check("rst_rd_en", {ch1_rd_en, ch0_rd_en}, 0);
        rst = 1'b0;

        // ---- FFT completion strobe in IDLE is ignored ----
        m_axis_data_tlast = 1'b1;
        tick();
        m_axis_data_tlast = 1'b0;
        check("idle_tlast_ignored_done", frame_done, 0);
        check("idle_tlast_ignored_busy", busy, 0);

        // ---- single channel 0 frame, data 1..8 ----
        for (int i = 1; i <= NS; i++) push(0, DW'(i));
        #1;
        check("idle_no_beat", s_axis_tvalid, 0);
        s_axis_tready = 1'b1;
        tick();
        check("stream_busy", busy, 1);
        run_frame(1'b0, 16'd1, 1'b1);

        // ---- threshold: 7 buffered is not enough ----
        for (int i = 0; i < 7; i++) push(0, 16'h0031 + DW'(i));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("below_threshold_busy", busy, 0);
            check("below_threshold_tvalid", s_axis_tvalid, 0);
        end
        push(0, 16'h0038);
        #1;
        check("grant_cycle_no_beat", s_axis_tvalid, 0);
        tick();
        check("first_beat_after_grant", s_axis_tvalid, 1);
        run_frame(1'b0, 16'h0031, 1'b1);

        // ---- channel 1 frame with tready toggling ----
        for (int i = 0; i < NS; i++) push(1, 16'h0041 + DW'(i));
        tick();
        for (int r = 0; r < 16; r++) begin
            s_axis_tready = vecs[r].tready;
            #1;
            check("tog_tvalid", s_axis_tvalid, vecs[r].exp_valid);
            check("tog_tdata", s_axis_tdata, vecs[r].exp_data);
            check("tog_tlast", s_axis_tlast, vecs[r].exp_last);
            check("tog_tuser", s_axis_tuser, vecs[r].exp_user);
            check("tog_rd0", ch0_rd_en, vecs[r].exp_rd0);
            check("tog_rd1", ch1_rd_en, vecs[r].exp_rd1);
            tick();
        end
        s_axis_tready = 1'b1;
        check("tog_all_popped", ch1_count, 0);
        check("tog_wait_tvalid", s_axis_tvalid, 0);
        finish_frame(1'b1);

        // ---- both channels eligible: alternate starting with channel 0 ----
        for (int i = 0; i < 2 * NS; i++) begin
            push(0, 16'h0100 + DW'(i));
            push(1, 16'h0200 + DW'(i));
        end
        run_frame(1'b0, 16'h0100, 1'b1);
        run_frame(1'b1, 16'h0200, 1'b1);
        run_frame(1'b0, 16'h0108, 1'b1);
        run_frame(1'b1, 16'h0208, 1'b1);

        // ---- reset at beat 4 aborts the frame ----
        for (int i = 0; i < NS; i++) push(0, 16'h0051 + DW'(i));
        n = 0;
        while (!s_axis_tvalid && n < 10) begin
            tick();
            n++;
        end
        for (int b = 0; b < 4; b++) begin
            check("pre_rst_tdata", s_axis_tdata, 16'h0051 + DW'(b));
            tick();
        end
        rst           = 1'b1;
        s_axis_tready = 1'b0;
        tick();
        rst           = 1'b0;
        s_axis_tready = 1'b1;
        #1;
        check("abort_tvalid", s_axis_tvalid, 0);
        check("abort_busy", busy, 0);
        check("abort_rd_en", {ch1_rd_en, ch0_rd_en}, 0);
        check("abort_fifo_kept", ch0_count, 4);
        tick();
        check("abort_no_regrant", busy, 0);
        for (int i = 0; i < 4; i++) push(0, 16'h0059 + DW'(i));
        run_frame(1'b0, 16'h0055, 1'b1);

        // ---- WAIT_FFT without completion ----
        for (int i = 0; i < NS; i++) push(1, 16'h0061 + DW'(i));
        run_frame(1'b1, 16'h0061, 1'b0);
        for (int i = 0; i < NS; i++) begin
            push(0, 16'h0081 + DW'(i));
            push(1, 16'h0071 + DW'(i));
        end
        n        = 0;
        saw_done = 1'b0;
`ifdef SCHED_TIMEOUT_EN
        while (busy && n < 40) begin
            tick();
            n++;
            if (frame_done) saw_done = 1'b1;
        end
        check("timeout_wait_cycles", n, TO);
        check("timeout_no_frame_done", saw_done, 0);
        check("timeout_err_set", timeout_err, 1);
        check("timeout_idle", busy, 0);
`else
        repeat (40) begin
            tick();
            if (frame_done) saw_done = 1'b1;
        end
        check("no_watchdog_still_busy", busy, 1);
        check("no_watchdog_no_done", saw_done, 0);
        check("no_watchdog_err", timeout_err, 0);
        finish_frame(1'b1);
`endif
        run_frame(1'b0, 16'h0081, 1'b1);
`ifdef SCHED_TIMEOUT_EN
        check("timeout_err_sticky", timeout_err, 1);
`else
        check("timeout_err_tied", timeout_err, 0);
`endif
        run_frame(1'b1, 16'h0071, 1'b1);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule

// File: doc/fft_frame_scheduler.md
Name: fft_frame_scheduler

Overview:
- Shares a single FFT core's AXI4-Stream input between two sample FIFOs (channel 0, channel 1).
- Grants one whole frame of NUM_SAMPLES beats to a channel, using round-robin when both are eligible.
- Drives the beats with tlast on the final beat, then holds off until the FFT reports frame completion (m_axis_data_tlast).
- Sits between the two capture FIFOs and the FFT s_axis port, and replaces the per-channel FIFO reader.

Parameters:
- DATA_WIDTH, 16: sample width on FIFO dout and s_axis_tdata.
- NUM_SAMPLES, 1024: beats per frame; must be >= 2.
- CNT_WIDTH, 11: width of the FIFO data_count inputs.
- TIMEOUT_CYCLES, 65535: WAIT_FFT watchdog limit; used only with SCHED_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; every register is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ch0_dout  in  DATA_WIDTH  channel 0 FIFO output; first-word-fall-through, valid while !ch0_empty.
- ch0_empty  in  1  channel 0 FIFO empty.
- ch0_count  in  CNT_WIDTH  channel 0 FIFO data_count.
- ch0_rd_en  out  1  channel 0 pop.
- ch1_dout / ch1_empty / ch1_count / ch1_rd_en: same definitions as channel 0.
- s_axis_tready  in  1  FFT input ready.
- s_axis_tvalid  out  1  beat valid.
- s_axis_tdata  out  DATA_WIDTH  beat data.
- s_axis_tlast  out  1  last beat of frame.
- s_axis_tuser  out  1  id of the granted channel.
- m_axis_data_tlast  in  1  FFT output last-beat strobe; marks frame completion.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when a frame completes.
- frame_ch  out  1  channel of the most recent completed frame.
- timeout_err  out  1  sticky watchdog flag; tied 0 when SCHED_TIMEOUT_EN is undefined.

Behaviour:
- Reset:
  - rst synchronous, active-high.
  - State = IDLE, beat counter = 0, round-robin pointer last_ch = 1, so channel 0 wins the first tie.
  - Registered outputs (busy, frame_done, frame_ch, timeout_err) reset to 0; s_axis_tuser, s_axis_tvalid, s_axis_tlast, s_axis_tdata and rd_en are combinational and are therefore 0 in IDLE.
  - Reset during any state aborts the frame immediately; FIFO contents are not flushed.
- Eligibility: chN_req = (chN_count >= NUM_SAMPLES). A frame is granted only when fully buffered, so no mid-frame underrun is expected.
- States:
  - IDLE: if exactly one req, grant it; if both, grant !last_ch; if none, stay. On grant, latch sel and clear the beat counter; the state is STREAM on the next cycle. No beats are issued in IDLE.
  - STREAM:
    - s_axis_tvalid = !empty[sel]; s_axis_tdata = dout[sel]; s_axis_tuser = sel.
    - rd_en[sel] = tvalid && tready; rd_en of the other channel = 0.
    - Beat counter increments per handshake.
    - s_axis_tlast = tvalid && (cnt == NUM_SAMPLES-1).
    - The handshake on the last beat moves to WAIT_FFT.
    - If empty[sel] rises mid-frame, tvalid drops and the counter holds; streaming resumes when data returns.
  - WAIT_FFT:
    - tvalid = 0 and both rd_en = 0.
    - On m_axis_data_tlast: go to IDLE, pulse frame_done for one cycle, frame_ch <= sel, last_ch <= sel.
- m_axis_data_tlast in IDLE or STREAM is ignored.
- The beat counter is $clog2(NUM_SAMPLES+1) bits wide and never wraps: it is cleared on grant.
- Latency: with req already high, first beat valid 1 cycle after grant. Minimum gap between frames is 2 cycles (WAIT_FFT exit, then IDLE grant).
- tdata/tvalid are combinational from the FIFO; the FFT must not combinationally feed tready back from tvalid.

Optional Feature:
- Macro SCHED_TIMEOUT_EN:
  - Defined: a watchdog counts cycles in WAIT_FFT. On reaching TIMEOUT_CYCLES, state goes to IDLE, timeout_err is set sticky (cleared only by rst), frame_done is NOT pulsed, and last_ch is updated so the other channel gets priority.
  - Undefined: no counter; WAIT_FFT waits indefinitely; timeout_err = 0.

Decomposition:
- Package fft_sched_pkg holds:
  - state enum {IDLE, STREAM, WAIT_FFT};
  - ch_id_t (1 bit) and the constants CH0, CH1;
  - the default NUM_SAMPLES.
- Sub-module rr_arbiter2: two requests plus a last_ch input, giving a one-hot grant and a grant_id; purely combinational.

Test Plan (NUM_SAMPLES=8, DATA_WIDTH=16):
- ch0_count=8, ch1_count=0, tready=1 -> 8 beats ch0 data 1..8, tlast on beat 8 only, tuser=0, then stall until m_axis_data_tlast -> frame_done pulse, frame_ch=0.
- Both counts=8 continuously, FFT tlast 5 cycles after each frame -> grants alternate 0,1,0,1; first grant goes to channel 0.
- tready toggled 1/0 every cycle during a ch1 frame -> exactly 8 handshakes, rd_en only on handshakes, data order preserved, tlast held until accepted.
- ch0_count=7 -> no grant, busy=0; count rises to 8 -> tvalid on the cycle after the grant.
- rst pulsed at beat 4 -> next cycle tvalid=0, busy=0, rd_en=0; after release a new frame starts at beat 0.
- SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=20, no m_axis_data_tlast -> IDLE after 20 WAIT_FFT cycles, timeout_err=1, no frame_done, next grant to the other channel.
